// File: rtl/logic_gate_pkg.sv
// Shared encodings for the gate sweeper and the reference gate model.
package logic_gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/gate_ref.sv
// Reference model of an N-input gate: bitwise reduction of vec selected by op.
module gate_ref
  import logic_gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            expected
);

  always_comb begin
    expected = &vec;
    case (op)
      OP_AND:  expected = &vec;
      OP_OR:   expected = |vec;
      OP_XOR:  expected = ^vec;
      OP_NAND: expected = ~&vec;
      OP_NOR:  expected = ~|vec;
      OP_XNOR: expected = ~^vec;
      default: expected = &vec;  // reserved codes behave as AND
    endcase
  end

endmodule

// File: rtl/logic_gate_sweeper.sv
// Truth-table sweeper: steps every input vector through the gate under test,
// holds each for DWELL cycles and counts mismatches against gate_ref.
module logic_gate_sweeper
  import logic_gate_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DWELL = 4,
  localparam int CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             z_in,
  output logic [N_IN-1:0]  x_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [N_IN-1:0]  first_fail
);

  localparam int DW_W = $clog2(DWELL) + 1;
  localparam logic [N_IN:0]      VEC_LAST   = (N_IN + 1)'((1 << N_IN) - 1);
  localparam logic [DW_W-1:0]    DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  state_e          state;
  logic [2:0]      op_q;
  logic [N_IN:0]   vec;  // one extra bit so the terminal compare cannot wrap
  logic [DW_W-1:0] dwell_cnt;

  logic             expected;
  logic             sample;
  logic             mismatch;
  logic [CNT_W-1:0] err_nxt;

  gate_ref #(
    .N_IN(N_IN)
  ) u_gate_ref (
    .op      (op_q),
    .vec     (vec[N_IN-1:0]),
    .expected(expected)
  );

  always_comb begin
    sample   = (state == ST_DRIVE) && (dwell_cnt == DWELL_LAST);
    mismatch = sample && (z_in != expected);
    err_nxt  = err_cnt;
    if (mismatch && (err_cnt != CNT_MAX)) err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      vec        <= '0;
      dwell_cnt  <= '0;
      x_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q       <= op;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
            vec        <= '0;
            dwell_cnt  <= '0;
            x_out      <= '0;
            busy       <= 1'b1;
            state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          dwell_cnt <= dwell_cnt + 1'b1;
          if (sample) begin
            err_cnt   <= err_nxt;
            dwell_cnt <= '0;
            if (mismatch && !fail_valid) begin
              first_fail <= vec[N_IN-1:0];
              fail_valid <= 1'b1;
            end
            if (vec == VEC_LAST) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end else begin
              vec   <= vec + 1'b1;
              x_out <= N_IN'(vec + 1'b1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/logic_gate_sweeper.md
Name: logic_gate_sweeper

Overview:
- Hardware truth-table sweeper for an N-input logic gate under test.
- On start, it drives every input combination 0..2^N_IN-1 in order, holding each for DWELL clock cycles.
- In the last cycle of each hold it samples the gate output, compares it against a built-in reference for the selected operation, and counts mismatches.
- Sits beside the gate library as the on-board self-check, with results readable on LEDs.

Parameters:
- N_IN, 2, number of gate inputs (legal range 1..8).
- DWELL, 4, clock cycles each input vector is held (legal minimum 1); 12 MHz boards use e.g. 500000 for visible stepping.
- CNT_W, N_IN+1, width of the mismatch counter (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle sweep request
- op  in  3  gate operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved (evaluated as AND)
- z_in  in  1  output of the gate under test
- x_out  out  N_IN  input vector driven to the gate under test
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  last completed sweep had zero mismatches
- err_cnt  out  CNT_W  mismatches in the last/current sweep (saturating)
- fail_valid  out  1  at least one mismatch recorded
- first_fail  out  N_IN  vector of the first mismatch

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE. x_out, busy, done, pass, err_cnt, fail_valid, first_fail and all internal counters are 0.
- Reset mid-sweep takes effect at the next edge; the partial results are discarded.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 latches op into op_q.
  - Clears err_cnt, fail_valid, first_fail and pass; sets vec=0 and dwell_cnt=0.
  - Goes to DRIVE with busy=1 from the next cycle.
- DRIVE:
  - x_out=vec (registered).
  - dwell_cnt increments each cycle.
  - When dwell_cnt==DWELL-1:
    - z_in is sampled at that edge and compared with ref=gate_eval(op_q, vec).
    - On mismatch: err_cnt+1, saturating at 2^CNT_W-1. If fail_valid was 0, set first_fail=vec and fail_valid=1.
    - Then, if vec==2^N_IN-1, go to DONE; else vec+1 and dwell_cnt=0.
- Timing:
  - Each vector is held exactly DWELL cycles; busy is high for exactly 2^N_IN*DWELL cycles.
  - DWELL=1 is legal: a new vector every cycle, sampled in the same cycle.
- DONE (one cycle): done=1, busy=0, pass=(err_cnt==0 including the final compare); then return to IDLE.
- x_out holds the last vector after the sweep; it is not cleared.
- start is ignored while busy or in DONE. An op change mid-sweep has no effect (op_q is used).
- pass, err_cnt, fail_valid and first_fail hold until the next accepted start or rst.
- Reference (bitwise reduction of vec):
  - AND: &vec; OR: |vec; XOR: ^vec.
  - NAND, NOR, XNOR: the complements of the above.
- Widths: vec is N_IN+1 bits internally so the terminal compare cannot wrap. dwell_cnt is $clog2(DWELL)+1 bits.

Decomposition:
- Shared package logic_gate_pkg:
  - op encodings OP_AND..OP_XNOR (3-bit localparams).
  - FSM state encodings ST_IDLE, ST_DRIVE, ST_DONE.
- One combinational sub-module, gate_ref: input op and vec[N_IN-1:0], output the expected bit. It is reused later by other gate testers.
- Sweeper top holds the FSM, counters and result registers.

Test Plan:
1. N_IN=2, DWELL=4, op=AND, z_in=&x_out; start at cycle 0 -> busy cycles 1..16; x_out 00,01,10,11 for 4 cycles each; done pulse at cycle 17; pass=1, err_cnt=0, fail_valid=0.
2. Same setup, op=AND, z_in=|x_out (wrong gate) -> err_cnt=2, first_fail=2'b01, fail_valid=1, pass=0.
3. op=NAND, z_in stuck at 1 -> one mismatch at vec 11; err_cnt=1, first_fail=2'b11, pass=0.
4. start pulses during busy and during DONE, plus op changed to OR at cycle 6 -> sweep length unchanged at 16 cycles, results computed with AND, no restart.
5. rst asserted at cycle 6 mid-sweep -> next cycle all outputs 0 and state IDLE; a new start sweeps again from x_out=00 with cleared results.
6. N_IN=3, DWELL=1, op=XNOR, z_in=0 -> busy 8 cycles; mismatches at 000,011,101,110; err_cnt=4, first_fail=3'b000, pass=0.
